i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- Clocked I2C target (responder) for the other end of the bus from I2C_Controller.
- Oversamples i2c_scl/i2c_sda on the system clock and detects START/STOP.
- Matches a 7-bit address and ACKs it.
- Write transfers: shifts in bytes and presents each one on a valid strobe.
- Read transfers: serves bytes from a request/data handshake.
- Drives SDA open-drain only; no clock stretching.

Parameters:
- ADDRESS, 7'h1F, 7-bit target address that is ACKed.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA (minimum 2).

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous reset, active-high.
- i2c_scl  input  1  bus clock (pulled up externally).
- i2c_sda  inout  1  bus data; driven 1'b0 or 1'bz only, never 1'b1.
- rx_data  output  8  last received data byte.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- tx_data  input  8  byte to transmit on a read.
- tx_req  output  1  one-cycle pulse requesting the next tx_data.
- busy  output  1  high from address match until STOP, repeated START or NACK end.
- start_det  output  1  one-cycle pulse on START or repeated START.
- stop_det  output  1  one-cycle pulse on STOP.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, SDA released (z).
  - rx_data=8'h00; rx_valid, tx_req, busy, start_det, stop_det = 0.
  - Synchronizers preset to 1.
  - Reset asserted mid-transfer releases SDA on the next clock edge.
- Input path and edge detection:
  - SCL and SDA pass through SYNC_STAGES flops, then one history flop.
  - Rise/fall events fire SYNC_STAGES+1 clocks after the pin changes.
  - The bus must hold SCL high and low for at least 8 clocks each.
- Bus conditions:
  - START = SDA fall while SCL high; STOP = SDA rise while SCL high.
  - Both are valid in every state and take priority over bit events in the same cycle.
  - START -> ADDR with bit counter=0 and start_det pulse.
  - STOP -> IDLE with stop_det pulse, SDA released, busy=0.
- Bit timing:
  - Data is sampled on SCL rise, MSB first.
  - The target changes SDA only on SCL fall.
- States:
  - IDLE: ignores SCL/SDA edges except START.
  - ADDR:
    - Shifts 8 bits (7 address + R/W).
    - On the 8th SCL fall: if addr==ADDRESS, drive SDA low, busy=1, go to ADDR_ACK; else go to IGNORE with SDA released.
  - ADDR_ACK:
    - On SCL rise with R/W=1: pulse tx_req.
    - On SCL fall with R/W=0: release SDA, go to RX_BYTE.
    - On SCL fall with R/W=1: load the shifter from tx_data, drive its MSB, go to TX_BYTE.
    - tx_data must be stable within 4 clocks of tx_req.
  - RX_BYTE:
    - Shifts 8 bits.
    - On the 8th SCL fall: rx_data<=shifter, rx_valid pulse, drive SDA low, go to RX_ACK.
    - The target always ACKs data.
  - RX_ACK: on SCL fall, release SDA, go to RX_BYTE.
  - TX_BYTE:
    - On each SCL fall, drive the next bit; a 1 is released (z), a 0 is driven low.
    - After the 8th SCL fall, release SDA and go to TX_ACK.
  - TX_ACK:
    - Samples SDA on SCL rise.
    - ACK (0): pulse tx_req; on the next fall, load tx_data and go to TX_BYTE.
    - NACK (1): go to IGNORE with SDA released and busy=0.
  - IGNORE: SDA released; leaves only on START or STOP.
- Boundary conditions:
  - STOP or START mid-byte: the partial byte is discarded, with no rx_valid.
  - Repeated START while busy: busy drops in that cycle and is re-asserted on a new address match.
  - General-call address 0x00 is not ACKed unless ADDRESS==0.

Decomposition:
- Shared package i2c_pkg holds:
  - State enum (IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE).
  - I2C_RW_READ=1'b1.
  - Bit-count width 3.
- One natural sub-module: i2c_line_sync. It contains the synchronizer, history flop and rise/fall/START/STOP pulse generation, and is reusable by the controller.
- The FSM, shifter and SDA driver stay in i2c_target.

Test Plan:
- Write 0x1F (W), then data 0x20, then STOP:
  - ACK low during the 9th clock of each byte.
  - rx_valid pulses once with rx_data=8'h20.
  - stop_det pulses; busy ends 0.
- Address 0x2A (W):
  - SDA never driven low; no rx_valid; busy stays 0 through STOP.
- Read 0x1F (R), tx_data=8'hA5, then 8'h3C, then master ACK, then NACK:
  - Bus carries A5 then 3C, MSB first.
  - tx_req pulses twice; the target then goes to IGNORE and releases SDA.
- Write 0x1F, byte 0x55, then repeated START, then read 0x1F:
  - start_det pulses twice; rx_data=8'h55; the read byte follows.
- STOP after 4 data bits: no rx_valid; state IDLE; the next transfer works.
- reset asserted while the target is driving the ACK low:
  - SDA is z on the next clock; all outputs reach their reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target and its line synchronizer.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic        I2C_RW_READ = 1'b1;
  localparam int unsigned BIT_CNT_W   = 3;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the system clock domain and flags SCL edges and
// START/STOP bus conditions as single-cycle pulses.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;
  logic                   sda_rise;
  logic                   sda_fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o = scl_s & ~scl_hist_q;
  assign scl_fall_o = ~scl_s & scl_hist_q;
  assign sda_rise   = sda_o & ~sda_hist_q;
  assign sda_fall   = ~sda_o & sda_hist_q;

  // SCL must be high both before and after the SDA edge to count as a bus condition.
  assign start_o = sda_fall & scl_s & scl_hist_q;
  assign stop_o  = sda_rise & scl_s & scl_hist_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, write-byte reception and handshake-driven reads,
// open-drain SDA only, no clock stretching.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDRESS     = 7'h1F,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  i2c_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 byte_done_q, byte_done_d;
  logic [7:0]           shift_q, shift_d;
  logic                 rw_q, rw_d;
  logic                 sda_oe_q, sda_oe_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 tx_req_q, tx_req_d;
  logic                 busy_q, busy_d;
  logic                 start_det_q, start_det_d;
  logic                 stop_det_q, stop_det_d;

  logic sda_s, scl_rise, scl_fall, start_ev, stop_ev;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i      (clock),
    .rst_i      (reset),
    .scl_i      (i2c_scl),
    .sda_i      (i2c_sda),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_ev),
    .stop_o     (stop_ev)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      busy_q      <= busy_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    busy_d      = busy_q;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;

    if (start_ev) begin
      state_d     = ADDR;
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_ev) begin
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        // byte_done marks the 8th rise so the following fall closes the byte;
        // the fall right after START is therefore not mistaken for a boundary.
        ADDR, RX_BYTE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == '1) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == ADDRESS) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
                state_d  = ADDR_ACK;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = IGNORE;
              end
            end else begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = RX_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise) begin
            tx_req_d = (rw_q == I2C_RW_READ);
          end else if (scl_fall) begin
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            if (rw_q == I2C_RW_READ) begin
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              state_d  = TX_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = RX_BYTE;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d    = 1'b0;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            state_d     = RX_BYTE;
          end
        end
        TX_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == '1) byte_done_d = 1'b1;
          end else if (scl_fall) begin
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              sda_oe_d    = 1'b0;
              state_d     = TX_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
            end else begin
              busy_d   = 1'b0;
              sda_oe_d = 1'b0;
              state_d  = IGNORE;
            end
          end else if (scl_fall) begin
            shift_d     = tx_data;
            sda_oe_d    = ~tx_data[7];
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            state_d     = TX_BYTE;
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: state_d  = IDLE;
      endcase
    end
  end

  assign i2c_sda   = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign busy      = busy_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bus-level bench for i2c_target: a bit-banged I2C master with a transaction
// model of which addresses are ACKed and which bytes must appear.
module tb_i2c_target;

  localparam logic [6:0] TGT = 7'h1F;
  localparam int Q = 5;  // quarter of an SCL period, in system clocks

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        i2c_sda;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy, start_det, stop_det;

  pullup (i2c_sda);
  assign i2c_sda = m_low ? 1'b0 : 1'bz;

  i2c_target #(
    .ADDRESS    (TGT),
    .SYNC_STAGES(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .i2c_scl  (scl),
    .i2c_sda  (i2c_sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_rxv = 0, n_start = 0, n_stop = 0, n_txreq = 0, tgt_low = 0;
  logic [7:0] rx_log[$];
  logic [7:0] txq[$];

  always @(negedge clock) begin
    if (rx_valid) begin
      n_rxv++;
      rx_log.push_back(rx_data);
    end
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (tx_req) n_txreq++;
    if (!m_low && i2c_sda === 1'b0) tgt_low++;
  end

  // Read-data provider: hands out the next queued byte on each request.
  initial begin
    forever begin
      @(negedge clock);
      if (tx_req && txq.size() > 0) tx_data = txq.pop_front();
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic bus_sda();
    return (i2c_sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic wclk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wclk(Q);
    scl   = 1'b1; wclk(2 * Q);
    m_low = 1'b1; wclk(2 * Q);
    scl   = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wclk(Q);
    scl   = 1'b1; wclk(2 * Q);
    m_low = 1'b0; wclk(2 * Q);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_low = ~b; wclk(Q);
    scl   = 1'b1; wclk(Q);
    s     = bus_sda(); wclk(Q);
    scl   = 1'b0; wclk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(~ack, s);
  endtask

  task automatic write_xfer(input logic [6:0] a, input logic [7:0] d[$]);
    int rx0, st0, low0;
    logic acked, exp_ack;
    exp_ack = (a == TGT);
    rx0 = n_rxv; st0 = n_stop; low0 = tgt_low;
    i2c_start();
    send_byte({a, 1'b0}, acked);
    chk("wr_addr_ack", acked, exp_ack);
    if (exp_ack) begin
      foreach (d[i]) begin
        send_byte(d[i], acked);
        chk("wr_data_ack", acked, 1'b1);
      end
    end else begin
      send_byte(8'hFF, acked);
      chk("ignored_byte_ack", acked, 1'b0);
      chk("ignored_no_drive", tgt_low - low0, 0);
    end
    chk("wr_busy_mid", busy, exp_ack);
    i2c_stop(); wclk(4);
    chk("wr_rx_count", n_rxv - rx0, exp_ack ? d.size() : 0);
    if (exp_ack) foreach (d[i]) chk("wr_rx_byte", rx_log[rx0 + i], d[i]);
    chk("wr_stop_det", n_stop - st0, 1);
    chk("wr_busy_end", busy, 1'b0);
  endtask

  task automatic read_xfer(input logic [6:0] a, input int n);
    logic [7:0] exp_b[$];
    logic [7:0] b;
    logic acked, exp_ack;
    int tr0, low0;
    exp_ack = (a == TGT);
    for (int i = 0; i < n; i++) exp_b.push_back(8'($urandom));
    foreach (exp_b[i]) txq.push_back(exp_b[i]);
    tr0 = n_txreq; low0 = tgt_low;
    i2c_start();
    send_byte({a, 1'b1}, acked);
    chk("rd_addr_ack", acked, exp_ack);
    if (exp_ack) begin
      for (int i = 0; i < n; i++) begin
        recv_byte(i < n - 1, b);
        chk("rd_byte", b, exp_b[i]);
      end
      chk("rd_tx_req_count", n_txreq - tr0, n);
      chk("rd_busy_after_nack", busy, 1'b0);
      chk("rd_sda_released", bus_sda(), 1'b1);
    end else begin
      recv_byte(1'b0, b);
      chk("rd_ignored_byte", b, 8'hFF);
      chk("rd_ignored_no_drive", tgt_low - low0, 0);
      chk("rd_ignored_no_req", n_txreq - tr0, 0);
      txq.delete();
    end
    i2c_stop(); wclk(4);
    chk("rd_busy_end", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] b;
    logic acked, s;
    int st0, rx0;

    wclk(4);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_req", tx_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start_det", start_det, 1'b0);
    chk("rst_stop_det", stop_det, 1'b0);
    chk("rst_sda", bus_sda(), 1'b1);
    reset = 1'b0;
    wclk(4);

    // Directed write of one byte
    d = '{8'h20};
    write_xfer(TGT, d);
    chk("rx_data_20", rx_data, 8'h20);

    // Non-matching address and general call
    d = '{8'h11};
    write_xfer(7'h2A, d);
    write_xfer(7'h00, d);

    // Read A5 then 3C
    txq.push_back(8'hA5);
    txq.push_back(8'h3C);
    st0 = n_txreq;
    i2c_start();
    send_byte({TGT, 1'b1}, acked);
    chk("rd_dir_ack", acked, 1'b1);
    recv_byte(1'b1, b);
    chk("rd_dir_A5", b, 8'hA5);
    recv_byte(1'b0, b);
    chk("rd_dir_3C", b, 8'h3C);
    chk("rd_dir_tx_req", n_txreq - st0, 2);
    chk("rd_dir_released", bus_sda(), 1'b1);
    i2c_stop(); wclk(4);

    // Write 55, repeated START, then read
    st0 = n_start;
    txq.push_back(8'hC3);
    i2c_start();
    send_byte({TGT, 1'b0}, acked);
    send_byte(8'h55, acked);
    chk("rs_data_ack", acked, 1'b1);
    i2c_start();
    chk("rs_busy_dropped", busy, 1'b0);
    send_byte({TGT, 1'b1}, acked);
    chk("rs_read_ack", acked, 1'b1);
    chk("rs_busy_again", busy, 1'b1);
    recv_byte(1'b0, b);
    chk("rs_read_byte", b, 8'hC3);
    i2c_stop(); wclk(4);
    chk("rs_start_det", n_start - st0, 2);
    chk("rs_rx_data", rx_data, 8'h55);

    // STOP after four data bits discards the partial byte
    rx0 = n_rxv;
    i2c_start();
    send_byte({TGT, 1'b0}, acked);
    for (int i = 0; i < 4; i++) clk_bit(1'b0, s);
    i2c_stop(); wclk(4);
    chk("partial_no_rx", n_rxv - rx0, 0);
    chk("partial_busy", busy, 1'b0);
    d = '{8'h9E, 8'h01};
    write_xfer(TGT, d);

    // Reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      b = {TGT, 1'b0};
      clk_bit(b[i], s);
    end
    m_low = 1'b0;
    wclk(1);
    chk("ack_driven", bus_sda(), 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_sda_released", bus_sda(), 1'b1);
    wclk(1);
    chk("rst2_rx_data", rx_data, 8'h00);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_rx_valid", rx_valid, 1'b0);
    reset = 1'b0;
    wclk(4);
    i2c_stop(); wclk(4);

    // Randomized transactions against the model
    for (int t = 0; t < 8; t++) begin
      logic [6:0] a;
      int n;
      case ($urandom_range(2))
        0: a = TGT;
        1: a = 7'($urandom);
        default: a = 7'h00;
      endcase
      if ($urandom_range(3) != 0) a = TGT;
      n = $urandom_range(3, 1);
      if ($urandom_range(1) == 1) begin
        read_xfer(a, n);
      end else begin
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        write_xfer(a, d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
